// File: rtl/codec_pkg.sv
// Shared definitions for the codec init path: command indices, the WM8731
// register-word table and the I2C writer state encoding.
package codec_pkg;

    localparam logic [3:0] DUMMY_DATA  = 4'd0;
    localparam logic [3:0] SET_LIN_L   = 4'd1;
    localparam logic [3:0] SET_LIN_R   = 4'd2;
    localparam logic [3:0] SET_HEAD_L  = 4'd3;
    localparam logic [3:0] SET_HEAD_R  = 4'd4;
    localparam logic [3:0] A_PATH_CTRL = 4'd5;
    localparam logic [3:0] D_PATH_CTRL = 4'd6;
    localparam logic [3:0] POWER_ON    = 4'd7;
    localparam logic [3:0] SET_FORMAT  = 4'd8;
    localparam logic [3:0] SAMPLE_CTRL = 4'd9;
    localparam logic [3:0] SET_ACTIVE  = 4'd10;
    localparam logic [3:0] INIT_CMDS_N = 4'd11;

    typedef enum logic [2:0] {
        W_IDLE  = 3'd0,
        W_START = 3'd1,
        W_BYTE  = 3'd2,
        W_ACKB  = 3'd3,
        W_STOP  = 3'd4,
        W_DONE  = 3'd5
    } wr_state_t;

    // Indices outside 1..10 carry no register write.
    function automatic logic codec_is_dummy(input logic [3:0] idx);
        return (idx == DUMMY_DATA) || (idx >= INIT_CMDS_N);
    endfunction

    function automatic logic [15:0] codec_reg_word(input logic [3:0] idx);
        logic [15:0] w;
        case (idx)
            SET_LIN_L:   w = 16'h001A;
            SET_LIN_R:   w = 16'h021A;
            SET_HEAD_L:  w = 16'h047B;
            SET_HEAD_R:  w = 16'h067B;
            A_PATH_CTRL: w = 16'h08F8;
            D_PATH_CTRL: w = 16'h0A06;
            POWER_ON:    w = 16'h0C00;
            SET_FORMAT:  w = 16'h0E01;
            SAMPLE_CTRL: w = 16'h1002;
            SET_ACTIVE:  w = 16'h1201;
            default:     w = 16'h0000;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/codec_i2c_tick.sv
// Quarter-period divider: one tick_o pulse every QDIV enabled cycles.
// clr_i restarts the period so the first tick lands QDIV-1 cycles later.
module codec_i2c_tick #(
    parameter int QDIV = 125
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = ($clog2(QDIV) > 0) ? $clog2(QDIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(QDIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // The clearing edge itself counts as the first cycle of the new period.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = CW'(1);
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/codec_i2c_writer.sv
// Codec register writer: looks up a command's 16-bit word and sends it as a
// 3-byte I2C write. Optional CODEC_I2C_RETRY_EN restarts NACKed writes.
module codec_i2c_writer
    import codec_pkg::*;
#(
    parameter int         CLK_FREQ  = 50000000,
    parameter int         I2C_FREQ  = 100000,
    parameter logic [7:0] DEV_ADDR  = 8'h34,
    parameter int         MAX_RETRY = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cmd,
    input  logic       send,
    output logic       ack,
    output logic       ready,
    output logic       i2c_sclk,
    output logic       i2c_sdat_oe,
    input  logic       i2c_sdat_i,
    output logic       nack_err
);

    localparam int QDIV = CLK_FREQ / (4 * I2C_FREQ);

    // Handshake: send is a level sampled only in IDLE. Acceptance raises ack
    // and drops ready on the same edge; ack falls on the edge that sees
    // send low; ready returns only after the transfer ends with ack low.

    wr_state_t   state_q, state_d;
    logic [1:0]  qcnt_q, qcnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [1:0]  byte_q, byte_d;
    logic [15:0] word_q, word_d;
    logic        ack_q, ack_d;
    logic        ready_q, ready_d;
    logic        sclk_q, sclk_d;
    logic        sdat_oe_q, sdat_oe_d;
    logic        nack_err_q, nack_err_d;
    logic        tick, tick_clr, retry_abort;
    logic [7:0]  cur_byte;
    logic        cur_bit;

`ifdef CODEC_I2C_RETRY_EN
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RW-1:0] retry_q, retry_d;
    logic          try_nack_q, try_nack_d;
    assign retry_abort = try_nack_q;
`else
    assign retry_abort = 1'b0;
`endif

    codec_i2c_tick #(
        .QDIV (QDIV)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .en_i   (state_q != W_IDLE),
        .clr_i  (tick_clr),
        .tick_o (tick)
    );

    always_comb begin
        case (byte_q)
            2'd0:    cur_byte = DEV_ADDR;
            2'd1:    cur_byte = word_q[15:8];
            default: cur_byte = word_q[7:0];
        endcase
        cur_bit = cur_byte[3'd7 - bit_q];
    end

    always_comb begin
        state_d    = state_q;
        qcnt_d     = qcnt_q;
        bit_d      = bit_q;
        byte_d     = byte_q;
        word_d     = word_q;
        ack_d      = ack_q;
        ready_d    = ready_q;
        sclk_d     = sclk_q;
        sdat_oe_d  = sdat_oe_q;
        nack_err_d = nack_err_q;
        tick_clr   = 1'b0;
`ifdef CODEC_I2C_RETRY_EN
        retry_d    = retry_q;
        try_nack_d = try_nack_q;
`endif
        if (ack_q && !send) begin
            ack_d = 1'b0;
        end

        case (state_q)
            W_IDLE: begin
                if (send) begin
                    word_d   = codec_reg_word(cmd);
                    ack_d    = 1'b1;
                    ready_d  = 1'b0;
                    tick_clr = 1'b1;
                    qcnt_d   = 2'd0;
                    bit_d    = 3'd0;
                    byte_d   = 2'd0;
`ifdef CODEC_I2C_RETRY_EN
                    retry_d    = '0;
                    try_nack_d = 1'b0;
`endif
                    state_d  = codec_is_dummy(cmd) ? W_DONE : W_START;
                end
            end

            W_START: begin
                if (tick) begin
                    qcnt_d = qcnt_q + 2'd1;
                    case (qcnt_q)
                        2'd0: begin
                            sclk_d    = 1'b1;
                            sdat_oe_d = 1'b0;
                        end
                        2'd1: sdat_oe_d = 1'b1;
                        2'd2: sclk_d    = 1'b0;
                        2'd3: state_d   = W_BYTE;
                    endcase
                end
            end

            W_BYTE: begin
                if (tick) begin
                    qcnt_d = qcnt_q + 2'd1;
                    case (qcnt_q)
                        2'd0: begin
                            sclk_d    = 1'b0;
                            sdat_oe_d = ~cur_bit;
                        end
                        2'd1: sclk_d = 1'b1;
                        2'd2: ;
                        2'd3: begin
                            sclk_d = 1'b0;
                            bit_d  = bit_q + 3'd1;
                            if (bit_q == 3'd7) begin
                                state_d = W_ACKB;
                            end
                        end
                    endcase
                end
            end

            W_ACKB: begin
                if (tick) begin
                    qcnt_d = qcnt_q + 2'd1;
                    case (qcnt_q)
                        2'd0: begin
                            sclk_d    = 1'b0;
                            sdat_oe_d = 1'b0;
                        end
                        2'd1: sclk_d = 1'b1;
                        2'd2: begin
                            if (i2c_sdat_i) begin
`ifdef CODEC_I2C_RETRY_EN
                                try_nack_d = 1'b1;
`else
                                nack_err_d = 1'b1;
`endif
                            end
                        end
                        2'd3: begin
                            sclk_d = 1'b0;
                            bit_d  = 3'd0;
                            byte_d = byte_q + 2'd1;
                            state_d = (byte_q == 2'd2 || retry_abort) ? W_STOP : W_BYTE;
                        end
                    endcase
                end
            end

            W_STOP: begin
                if (tick) begin
                    qcnt_d = qcnt_q + 2'd1;
                    case (qcnt_q)
                        2'd0: sdat_oe_d = 1'b1;
                        2'd1: sclk_d    = 1'b1;
                        2'd2: sdat_oe_d = 1'b0;
                        2'd3: begin
                            state_d = W_DONE;
`ifdef CODEC_I2C_RETRY_EN
                            if (try_nack_q) begin
                                if (retry_q < RW'(MAX_RETRY)) begin
                                    retry_d    = retry_q + RW'(1);
                                    try_nack_d = 1'b0;
                                    byte_d     = 2'd0;
                                    bit_d      = 3'd0;
                                    state_d    = W_START;
                                end else begin
                                    nack_err_d = 1'b1;
                                end
                            end
`endif
                        end
                    endcase
                end
            end

            W_DONE: begin
                if (!ack_q) begin
                    ready_d = 1'b1;
                    state_d = W_IDLE;
                end
            end

            default: state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= W_IDLE;
            qcnt_q     <= 2'd0;
            bit_q      <= 3'd0;
            byte_q     <= 2'd0;
            word_q     <= 16'h0000;
            ack_q      <= 1'b0;
            ready_q    <= 1'b1;
            sclk_q     <= 1'b1;
            sdat_oe_q  <= 1'b0;
            nack_err_q <= 1'b0;
`ifdef CODEC_I2C_RETRY_EN
            retry_q    <= '0;
            try_nack_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            qcnt_q     <= qcnt_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            word_q     <= word_d;
            ack_q      <= ack_d;
            ready_q    <= ready_d;
            sclk_q     <= sclk_d;
            sdat_oe_q  <= sdat_oe_d;
            nack_err_q <= nack_err_d;
`ifdef CODEC_I2C_RETRY_EN
            retry_q    <= retry_d;
            try_nack_q <= try_nack_d;
`endif
        end
    end

    assign ack         = ack_q;
    assign ready       = ready_q;
    assign i2c_sclk    = sclk_q;
    assign i2c_sdat_oe = sdat_oe_q;
    assign nack_err    = nack_err_q;

endmodule

// File: tb/tb_codec_i2c_writer.sv
// Bench for codec_i2c_writer: behavioural initiator, I2C slave/decoder and a
// byte scoreboard fed by the driver and drained by the bus monitor.
module tb_codec_i2c_writer;
  localparam int CLK_HZ   = 2000000;
  localparam int I2C_HZ   = 100000;
  localparam int QD       = 5;          // CLK_HZ / (4 * I2C_HZ)
  localparam int XFER_CLK = 116 * QD;
  localparam int LIMIT    = 400 * QD;
`ifdef CODEC_I2C_RETRY_EN
  localparam int   NACK_LAT = 160 * QD; // aborted attempt (44 quarters) + full retry
  localparam logic EXP_NERR = 1'b0;
`else
  localparam int   NACK_LAT = XFER_CLK;
  localparam logic EXP_NERR = 1'b1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       send = 1'b0;
  logic [3:0] cmd = 4'd0;
  logic       ack, ready, i2c_sclk, i2c_sdat_oe, nack_err;
  logic       i2c_sdat_i;
  logic       slave_pull = 1'b0;

  assign i2c_sdat_i = ~(i2c_sdat_oe | slave_pull);

  codec_i2c_writer #(
    .CLK_FREQ  (CLK_HZ),
    .I2C_FREQ  (I2C_HZ),
    .DEV_ADDR  (8'h34),
    .MAX_RETRY (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd         (cmd),
    .send        (send),
    .ack         (ack),
    .ready       (ready),
    .i2c_sclk    (i2c_sclk),
    .i2c_sdat_oe (i2c_sdat_oe),
    .i2c_sdat_i  (i2c_sdat_i),
    .nack_err    (nack_err)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: cycles=%0d limit=60000", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] tb_word(input int c);
    case (c)
      1:  return 16'h001A;
      2:  return 16'h021A;
      3:  return 16'h047B;
      4:  return 16'h067B;
      5:  return 16'h08F8;
      6:  return 16'h0A06;
      7:  return 16'h0C00;
      8:  return 16'h0E01;
      9:  return 16'h1002;
      10: return 16'h1201;
      default: return 16'h0000;
    endcase
  endfunction

  // ---------------- I2C slave + bus monitor ----------------
  logic       prev_sc = 1'b1;
  logic       prev_line = 1'b1;
  logic       mon_in_frame = 1'b0;
  logic [7:0] shreg = 8'h00;
  int mon_bits = 0;
  int mon_byte = 0;
  int starts = 0;
  int stops = 0;
  int sclk_falls = 0;
  int nack_total = 0;
  int nack_done = 0;

  always @(negedge clk) begin
    logic sc, line, do_nack;
    logic [7:0] e;
    sc = i2c_sclk;
    line = i2c_sdat_i;
    if (rst) begin
      mon_in_frame = 1'b0;
      mon_bits = 0;
      mon_byte = 0;
      slave_pull = 1'b0;
    end else begin
      if (!sc && prev_sc) sclk_falls = sclk_falls + 1;
      if (sc && prev_sc && prev_line && !line) begin
        mon_in_frame = 1'b1;
        mon_bits = 0;
        mon_byte = 0;
        starts = starts + 1;
      end else if (sc && prev_sc && !prev_line && line && mon_in_frame) begin
        mon_in_frame = 1'b0;
        stops = stops + 1;
      end else if (mon_in_frame && sc && !prev_sc) begin
        if (mon_bits < 8) begin
          shreg = {shreg[6:0], line};
          mon_bits = mon_bits + 1;
          if (mon_bits == 8) begin
            if (exp_q.size() == 0) begin
              total = total + 1;
              bad = bad + 1;
              $display("FAIL bus_byte_unexpected: got 0x%02h expected none", shreg);
            end else begin
              e = exp_q.pop_front();
              check("bus_byte", 32'(shreg), 32'(e));
            end
          end
        end else begin
          mon_bits = 9;
        end
      end else if (mon_in_frame && !sc && prev_sc) begin
        if (mon_bits == 8) begin
          do_nack = (mon_byte == 0) && (nack_done < nack_total);
          if (do_nack) nack_done = nack_done + 1;
          slave_pull = !do_nack;
        end else if (mon_bits == 9) begin
          slave_pull = 1'b0;
          mon_bits = 0;
          mon_byte = mon_byte + 1;
        end
      end
    end
    prev_sc = sc;
    prev_line = i2c_sdat_i;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!ready && n < LIMIT) begin
      @(negedge clk);
      n = n + 1;
    end
    if (!ready) begin
      total = total + 1;
      bad = bad + 1;
      $display("FAIL %s_timeout: ready still 0 after %0d cycles, expected 1", name, LIMIT);
    end
  endtask

  // exp_lat < 0 marks a dummy command; nacks NACKs the address byte that often.
  task automatic do_cmd(input int c, input int nacks, input int exp_lat, input logic toggle);
    int t0, n, falls0;
    logic [15:0] w;
    wait_ready("pre_cmd");
    w = tb_word(c);
    nack_total = nack_total + nacks;
    if (exp_lat >= 0) begin
`ifdef CODEC_I2C_RETRY_EN
      for (int k = 0; k < nacks; k++) exp_q.push_back(8'h34);
`endif
      exp_q.push_back(8'h34);
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
    end
    falls0 = sclk_falls;
    cmd = 4'(c);
    send = 1'b1;
    @(negedge clk);
    check("ack_rise", 32'(ack), 32'd1);
    check("ready_fall", 32'(ready), 32'd0);
    t0 = cyc;
    send = 1'b0;
    if (toggle) begin
      n = 0;
      while (!(mon_byte == 1 && mon_bits >= 2) && n < LIMIT) begin
        @(negedge clk);
        n = n + 1;
      end
      check("toggle_reached_byte", 32'(mon_byte == 1), 32'd1);
      for (int k = 0; k < 3; k++) begin
        send = 1'b1;
        @(negedge clk);
        check("toggle_ack_hold", 32'(ack), 32'd0);
        send = 1'b0;
        @(negedge clk);
        check("toggle_ready_hold", 32'(ready), 32'd0);
      end
    end
    wait_ready("xfer");
    if (ready) begin
      if (exp_lat >= 0) begin
        check("ready_latency", 32'(cyc - t0), 32'(exp_lat));
      end else begin
        check("dummy_ready_within_3", 32'((cyc - t0) <= 3), 32'd1);
        check("dummy_no_sclk", 32'(sclk_falls - falls0), 32'd0);
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_sclk", 32'(i2c_sclk), 32'd1);
    check("rst_sdat_oe", 32'(i2c_sdat_oe), 32'd0);
    check("rst_nack_err", 32'(nack_err), 32'd0);

    do_cmd(1, 0, XFER_CLK, 1'b0);
    do_cmd(0, 0, -1, 1'b0);
    do_cmd(13, 0, -1, 1'b0);

    for (int c = 1; c <= 10; c++) do_cmd(c, 0, XFER_CLK, 1'b0);
    check("sweep_nack_err", 32'(nack_err), 32'd0);
    check("sweep_frames", 32'(starts), 32'd11);
    check("sweep_stops", 32'(stops), 32'd11);

    do_cmd(4, 0, XFER_CLK, 1'b1);

    do_cmd(6, 1, NACK_LAT, 1'b0);
    check("nack_err_after_nack", 32'(nack_err), 32'(EXP_NERR));
    do_cmd(7, 0, XFER_CLK, 1'b0);
    check("nack_err_sticky", 32'(nack_err), 32'(EXP_NERR));

    // Reset while the first address bit is on the bus.
    wait_ready("pre_midreset");
    cmd = 4'd3;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    n = 0;
    while (!(mon_in_frame && mon_byte == 0 && mon_bits == 1) && n < LIMIT) begin
      @(negedge clk);
      n = n + 1;
    end
    check("midreset_sdat_low_before", 32'(i2c_sdat_oe), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midreset_sclk", 32'(i2c_sclk), 32'd1);
    check("midreset_sdat_oe", 32'(i2c_sdat_oe), 32'd0);
    check("midreset_ack", 32'(ack), 32'd0);
    check("midreset_ready", 32'(ready), 32'd1);
    check("midreset_nack_err", 32'(nack_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    do_cmd(5, 0, XFER_CLK, 1'b0);
    check("final_nack_err", 32'(nack_err), 32'd0);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/codec_i2c_writer.md
Name: codec_i2c_writer

Overview:
- Responder side of the codec init command handshake; the codec init FSM is the initiator.
- Accepts a command index (`cmd`) with a `send` request and looks up the 16-bit codec register word for that index.
- Serialises the word as a 3-byte I2C write (device address, reg[15:8], reg[7:0]) to the WM8731-class codec.
- Answers with `ack` on acceptance and `ready` on completion; drives the codec I2C pins directly.

Parameters:
- CLK_FREQ, 50000000: system clock frequency in Hz.
- I2C_FREQ, 100000: SCLK frequency in Hz. Quarter-period divider QDIV = CLK_FREQ/(4*I2C_FREQ), 125 at defaults.
- DEV_ADDR, 8'h34: codec write address byte (R/W bit = 0 included).
- MAX_RETRY, 3: retry limit, used only with CODEC_I2C_RETRY_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- cmd  in  4  command index: 0 dummy, 1..10 register writes
- send  in  1  request from the initiator, level; sampled only in IDLE
- ack  out  1  request accepted; held high until `send` is seen low
- ready  out  1  high when idle and the previous command is complete
- i2c_sclk  out  1  I2C clock, push-pull, idles high
- i2c_sdat_oe  out  1  1 pulls SDAT low, 0 releases it (external pull-up)
- i2c_sdat_i  in  1  sampled SDAT, used for the codec ACK bit
- nack_err  out  1  sticky: some byte was NACKed since reset

Behaviour:
- Reset values: ack=0, ready=1, i2c_sclk=1, i2c_sdat_oe=0, nack_err=0. State is IDLE; divider and counters are cleared. Reset mid-transfer releases the bus on the next edge; no STOP is generated.
- Register LUT, indexed by cmd:
  - 1=16'h001A, 2=16'h021A, 3=16'h047B, 4=16'h067B, 5=16'h08F8
  - 6=16'h0A06, 7=16'h0C00, 8=16'h0E01, 9=16'h1002, 10=16'h1201
  - 0 and any index >10 are dummy.
- Handshake:
  - IDLE with send=1 at an edge: latch cmd and the LUT word; ack<=1 and ready<=0 on the same edge.
  - ack stays 1 until send=0 is sampled, then clears on the next edge.
  - ready<=1 only once the transfer (or dummy) has finished and ack=0. A finished transfer waits in DONE for send=0.
  - send while not IDLE is ignored.
  - Dummy: no bus activity; goes straight to DONE.
- State machine: IDLE -> START -> BYTE (8 bits) -> ACKB, repeated for 3 bytes -> STOP -> DONE -> IDLE.
- Every bus action is paced by a quarter tick (one clk pulse every QDIV cycles). The divider runs only outside IDLE and restarts at acceptance.
- START (4 quarters): SDAT released with SCLK high, then SDAT low, then SCLK low.
- Each bit slot is 4 quarters:
  - q0: set SDAT (MSB first); SCLK low.
  - q1: SCLK high.
  - q2: hold; sample i2c_sdat_i in ACKB.
  - q3: SCLK low.
- ACKB: SDAT released. A sampled 1 means NACK: set nack_err and continue to the next byte.
- STOP (4 quarters): SDAT low, SCLK high, SDAT released.
- Total transfer is 116 quarters (4 + 27×4 + 4), i.e. 14500 clk at defaults. ready rises 1 clk after DONE when send is already low.

Optional Feature:
- Macro: CODEC_I2C_RETRY_EN.
- Defined: a NACK in any ACKB makes the block finish the current slot, issue STOP, and restart the whole 3-byte write from START. It makes at most MAX_RETRY retries; the retry counter resets at each accepted command. nack_err is set only when the final attempt is also NACKed.
- Undefined: single attempt, behaviour as above; the retry counter is not present.

Decomposition:
- Shared package codec_pkg holds:
  - command index constants (DUMMY_DATA..SET_ACTIVE, INIT_CMDS_N=11)
  - the register-word LUT as a constant function
  - the writer state enum
- Sub-module codec_i2c_tick: quarter-period divider with enable/clear inputs and a tick output.

Test Plan:
- Reset with send=0 -> ack=0, ready=1, sclk=1, sdat_oe=0. Hold reset mid-byte of a transfer -> bus released next edge.
- cmd=1, send=1, slave ACKs all bytes -> ack rises 1 clk later with ready=0. Bits decode as 0x34, 0x00, 0x1A between START and STOP. ready=1 exactly 14500 clk after acceptance (send dropped on ack).
- cmd=0 -> ack pulse, no SCLK edge, ready back to 1 within 3 clk of send low.
- Sweep cmd=1..10 with a behavioural initiator model -> 10 transfers, words match the LUT, nack_err=0.
- Slave NACKs the address byte once (retry macro undefined) -> full 116-quarter transfer, nack_err=1 sticky. With the macro defined -> second attempt succeeds and nack_err=0.
- Toggle send during BYTE -> no effect; ack stays at its current level.
